// File: rtl/alu_pkg.sv
// ALU control codes, arbiter FSM state encoding and opcode legality helper
// shared by the ALU access arbiter files.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_SLL = 4'b1110;
  localparam logic [3:0] ALU_NOP = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  function automatic logic is_legal_op(input logic [3:0] op);
    logic legal;
    case (op)
      ALU_AND, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR, ALU_SLL: legal = 1'b1;
      default:                                              legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/alu_rr_arbiter.sv
// Round-robin grant: first asserted valid at or after ptr, wrapping; produces
// a one-hot grant, its index and an any-grant flag. Purely combinational.
module alu_rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [1:0]         ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [1:0]         grant_idx,
  output logic               grant_any
);

  logic [3:0] valid_pad_s;
  logic [1:0] cand_s;

  function automatic logic [1:0] wrap_add(input logic [1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_REQ) begin
      sum = sum - NUM_REQ;
    end else begin
      sum = sum;
    end
    return sum[1:0];
  endfunction

  // Scan requesters starting at the pointer and pick the first valid one
  always_comb begin
    valid_pad_s                = 4'b0000;
    valid_pad_s[NUM_REQ-1:0]   = valid;
    grant_idx                  = 2'd0;
    grant_any                  = 1'b0;
    cand_s                     = 2'd0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_s = wrap_add(ptr, k);
      if (!grant_any && valid_pad_s[cand_s]) begin
        grant_any = 1'b1;
        grant_idx = cand_s;
      end else begin
        grant_any = grant_any;
      end
    end
    if (grant_any) begin
      grant = NUM_REQ'(1'b1) << grant_idx;
    end else begin
      grant = '0;
    end
  end

endmodule

// File: rtl/alu_access_arbiter.sv
// Shares one combinational ALU among NUM_REQ requesters: round-robin grant,
// operand latch, single EXEC cycle, registered response with backpressure.
// Optional opcode screening is built in when ALU_ARB_OPCHECK_EN is defined.
module alu_access_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [4*NUM_REQ-1:0]      req_op,
  input  logic [DATA_W*NUM_REQ-1:0] req_a,
  input  logic [DATA_W*NUM_REQ-1:0] req_b,
  input  logic [5*NUM_REQ-1:0]      req_shamt,
  output logic [DATA_W-1:0]         alu_rs,
  output logic [DATA_W-1:0]         alu_rt,
  output logic [4:0]                alu_shamt,
  output logic [3:0]                alu_ctrl,
  input  logic [DATA_W-1:0]         alu_result,
  input  logic                      alu_zero,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [1:0]                rsp_id,
  output logic [DATA_W-1:0]         rsp_result,
  output logic                      rsp_zero,
  output logic                      rsp_err
);

  arb_state_e          state_r, state_s;
  logic [1:0]          ptr_r, ptr_s;
  logic [NUM_REQ-1:0]  grant_s;
  logic [1:0]          grant_idx_s;
  logic                grant_any_s;
  logic                accept_s;
  logic                op_legal_s;
  logic [3:0]          op_r;
  logic [DATA_W-1:0]   a_r, b_r;
  logic [4:0]          shamt_r;
  logic [1:0]          id_r;
  logic [DATA_W-1:0]   rsp_result_r;
  logic                rsp_zero_r, rsp_err_r;

  alu_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .valid     (req_valid),
    .ptr       (ptr_r),
    .grant     (grant_s),
    .grant_idx (grant_idx_s),
    .grant_any (grant_any_s)
  );

`ifdef ALU_ARB_OPCHECK_EN
  assign op_legal_s = is_legal_op(op_r);
`else
  assign op_legal_s = 1'b1;
`endif

  // Next state, grant acceptance and pointer advance
  always_comb begin
    state_s   = state_r;
    ptr_s     = ptr_r;
    req_ready = '0;
    accept_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (grant_any_s) begin
          req_ready = grant_s;
          accept_s  = 1'b1;
          state_s   = ST_EXEC;
          ptr_s     = (grant_idx_s == 2'(NUM_REQ - 1)) ? 2'd0 : grant_idx_s + 2'd1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_EXEC: state_s = ST_RESP;
      ST_RESP: begin
        if (rsp_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RESP;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // ALU control is live only in EXEC, and only for screened-legal opcodes
  always_comb begin
    if (state_r == ST_EXEC && op_legal_s) begin
      alu_ctrl = op_r;
    end else begin
      alu_ctrl = ALU_NOP;
    end
  end

  // FSM state and round-robin pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      ptr_r   <= 2'd0;
    end else begin
      state_r <= state_s;
      ptr_r   <= ptr_s;
    end
  end

  // Operand latch on the accepting edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r    <= 4'd0;
      a_r     <= '0;
      b_r     <= '0;
      shamt_r <= 5'd0;
      id_r    <= 2'd0;
    end else if (accept_s) begin
      op_r    <= req_op[4*grant_idx_s +: 4];
      a_r     <= req_a[DATA_W*grant_idx_s +: DATA_W];
      b_r     <= req_b[DATA_W*grant_idx_s +: DATA_W];
      shamt_r <= req_shamt[5*grant_idx_s +: 5];
      id_r    <= grant_idx_s;
    end else begin
      op_r    <= op_r;
      a_r     <= a_r;
      b_r     <= b_r;
      shamt_r <= shamt_r;
      id_r    <= id_r;
    end
  end

  // Result capture at the end of EXEC; held unchanged through RESP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_result_r <= '0;
      rsp_zero_r   <= 1'b0;
      rsp_err_r    <= 1'b0;
    end else if (state_r == ST_EXEC) begin
      rsp_result_r <= op_legal_s ? alu_result : '0;
      rsp_zero_r   <= op_legal_s & alu_zero;
      rsp_err_r    <= ~op_legal_s;
    end else begin
      rsp_result_r <= rsp_result_r;
      rsp_zero_r   <= rsp_zero_r;
      rsp_err_r    <= rsp_err_r;
    end
  end

  assign alu_rs     = a_r;
  assign alu_rt     = b_r;
  assign alu_shamt  = shamt_r;
  assign rsp_valid  = (state_r == ST_RESP);
  assign rsp_id     = id_r;
  assign rsp_result = rsp_result_r;
  assign rsp_zero   = rsp_zero_r;
  assign rsp_err    = rsp_err_r;

endmodule

// File: tb/tb_alu_access_arbiter.sv
// Self-checking bench for alu_access_arbiter: directed vector table, corner
// sequences and a randomized phase against a transaction-level model.
module tb_alu_access_arbiter;

  localparam int NR = 2;
  localparam int DW = 32;
`ifdef ALU_ARB_OPCHECK_EN
  localparam bit OPCHK = 1'b1;
`else
  localparam bit OPCHK = 1'b0;
`endif
  localparam logic [3:0] ILL_OP = 4'b0101;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req_valid, req_ready;
  logic [4*NR-1:0]   req_op;
  logic [DW*NR-1:0]  req_a, req_b;
  logic [5*NR-1:0]   req_shamt;
  logic [DW-1:0]     alu_rs, alu_rt, alu_result;
  logic [4:0]        alu_shamt;
  logic [3:0]        alu_ctrl;
  logic              alu_zero;
  logic              rsp_valid, rsp_ready;
  logic [1:0]        rsp_id;
  logic [DW-1:0]     rsp_result;
  logic              rsp_zero, rsp_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_access_arbiter #(.NUM_REQ(NR), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_shamt(req_shamt),
    .alu_rs(alu_rs), .alu_rt(alu_rt), .alu_shamt(alu_shamt), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_err(rsp_err)
  );

  // Behavioural ALU the arbiter fronts; unknown codes give a marker value
  function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [4:0] sh);
    case (op)
      4'b0000: return a & b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1100: return ~(a | b);
      4'b1110: return b << sh;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  always_comb begin
    alu_result = alu_fn(alu_ctrl, alu_rs, alu_rt, alu_shamt);
    alu_zero   = (alu_rs == alu_rt);
  end

  function automatic bit legal(input logic [3:0] op);
    return op inside {4'b0000, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1110};
  endfunction

  // Expected response for a transaction
  task automatic ref_rsp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, output logic [31:0] res, output logic z,
                         output logic err);
    if (OPCHK && !legal(op)) begin
      res = 32'd0; z = 1'b0; err = 1'b1;
    end else begin
      res = alu_fn(op, a, b, sh); z = (a == b); err = 1'b0;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic set_payload(input int id, input logic [3:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [4:0] sh);
    req_op[4*id +: 4]     = op;
    req_a[32*id +: 32]    = a;
    req_b[32*id +: 32]    = b;
    req_shamt[5*id +: 5]  = sh;
  endtask

  // One full transaction from requester id; called and returning at a negedge
  task automatic run_txn(input int id, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh, input int hold,
                         output logic [31:0] res, output logic z, output logic err,
                         output logic [1:0] rid);
    int waited;
    set_payload(id, op, a, b, sh);
    req_valid[id] = 1'b1;
    waited = 0;
    #1;
    while (req_ready == '0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk("grant", 32'(req_ready), 32'(1) << id);
    @(posedge clk);
    #1 req_valid[id] = 1'b0;
    @(negedge clk);
    chk("exec_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("exec_alu_ctrl", 32'(alu_ctrl), (OPCHK && !legal(op)) ? 32'hF : 32'(op));
    @(negedge clk);
    chk("resp_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("resp_alu_ctrl", 32'(alu_ctrl), 32'hF);
    res = rsp_result; z = rsp_zero; err = rsp_err; rid = rsp_id;
    if (hold > 0) req_valid[1-id] = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_result", rsp_result, res);
      chk("hold_id", 32'(rsp_id), 32'(rid));
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    req_valid = '0;
    @(negedge clk);
    chk("after_hs_valid", 32'(rsp_valid), 32'd0);
  endtask

  typedef struct {
    int          id;
    logic [3:0]  op;
    logic [31:0] a, b;
    logic [4:0]  sh;
    logic [31:0] res;
    logic        zero;
  } vec_t;

  typedef struct {
    int          id;
    logic [3:0]  op;
    logic [31:0] a, b;
    logic [4:0]  sh;
  } txn_t;

  function automatic int exp_grant(input logic [NR-1:0] v, input int p);
    for (int k = 0; k < NR; k++) begin
      if (v[(p + k) % NR]) return (p + k) % NR;
    end
    return -1;
  endfunction

  vec_t        vecs[8];
  logic [31:0] r_res;
  logic        r_z, r_err;
  logic [1:0]  r_id;
  int          grants[4], rids[4], rzero[4], rres[4];
  int          ng, nr, cyc, g, ptr_m;
  bit          busy_m;
  logic [NR-1:0] pend, drop;
  txn_t        exp_q[$];
  txn_t        t;
  logic [3:0]  ops_tbl[7];

  initial begin
    rst_n = 1'b0; req_valid = '0; req_op = '0; req_a = '0; req_b = '0;
    req_shamt = '0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_result", rsp_result, 32'd0);
    chk("rst_rsp_zero", 32'(rsp_zero), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_alu_ctrl", 32'(alu_ctrl), 32'hF);
    chk("rst_alu_rs", alu_rs, 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    vecs[0] = '{0, 4'b0010, 32'd5,         32'd7,         5'd0, 32'd12,        1'b0};
    vecs[1] = '{1, 4'b0110, 32'd9,         32'd9,         5'd0, 32'd0,         1'b1};
    vecs[2] = '{0, 4'b0111, 32'd3,         32'd8,         5'd0, 32'd1,         1'b0};
    vecs[3] = '{1, 4'b1110, 32'd0,         32'h1,         5'd4, 32'h10,        1'b0};
    vecs[4] = '{0, 4'b1100, 32'd0,         32'd0,         5'd0, 32'hFFFF_FFFF, 1'b1};
    vecs[5] = '{1, 4'b0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0, 32'h00F0_00F0, 1'b0};
    vecs[6] = '{0, 4'b0111, 32'hFFFF_FFFF, 32'd1,         5'd0, 32'd1,         1'b0};
    vecs[7] = '{1, 4'b0110, 32'd3,         32'd5,         5'd0, 32'hFFFF_FFFE, 1'b0};
    for (int i = 0; i < 8; i++) begin
      run_txn(vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh, 0, r_res, r_z, r_err, r_id);
      chk($sformatf("vec%0d_result", i), r_res, vecs[i].res);
      chk($sformatf("vec%0d_zero", i), 32'(r_z), 32'(vecs[i].zero));
      chk($sformatf("vec%0d_err", i), 32'(r_err), 32'd0);
      chk($sformatf("vec%0d_id", i), 32'(r_id), 32'(vecs[i].id));
    end

    // Backpressure: response held 5 cycles while another requester waits
    run_txn(0, 4'b0010, 32'd100, 32'd23, 5'd0, 5, r_res, r_z, r_err, r_id);
    chk("bp_result", r_res, 32'd123);

    // Illegal opcode handling
    run_txn(0, ILL_OP, 32'd5, 32'd5, 5'd0, 0, r_res, r_z, r_err, r_id);
    chk("ill_result", r_res, OPCHK ? 32'd0 : 32'hDEAD_BEEF);
    chk("ill_zero", 32'(r_z), OPCHK ? 32'd0 : 32'd1);
    chk("ill_err", 32'(r_err), OPCHK ? 32'd1 : 32'd0);

    // Reset during EXEC after granting req0 (pointer would otherwise favour req1)
    set_payload(0, 4'b0010, 32'd1, 32'd2, 5'd0);
    req_valid[0] = 1'b1;
    cyc = 0;
    #1;
    while (req_ready == '0 && cyc < 20) begin @(negedge clk); cyc++; end
    chk("mid_rst_grant", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_alu_ctrl", 32'(alu_ctrl), 32'hF);
    chk("mid_rst_alu_rs", alu_rs, 32'd0);
    repeat (2) @(negedge clk);
    chk("mid_rst_valid_later", 32'(rsp_valid), 32'd0);
    rst_n = 1'b1;

    // Both requesters continuously valid: grants must alternate from req0
    set_payload(0, 4'b0110, 32'd9, 32'd9, 5'd0);
    set_payload(1, 4'b0111, 32'd3, 32'd8, 5'd0);
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    ng = 0; nr = 0; cyc = 0;
    #1;
    while ((ng < 4 || nr < 4) && cyc < 60) begin
      if (req_ready != '0 && ng < 4) begin
        chk("alt_onehot", 32'(req_ready == 2'b01 || req_ready == 2'b10), 32'd1);
        grants[ng] = req_ready[1] ? 1 : 0;
        ng++;
      end
      if (rsp_valid && nr < 4) begin
        rids[nr] = int'(rsp_id); rzero[nr] = int'(rsp_zero); rres[nr] = int'(rsp_result);
        nr++;
        if (nr == 4) req_valid = '0;
      end
      @(negedge clk);
      cyc++;
    end
    chk("alt_rsp_count", 32'(nr), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("alt_grant%0d", i), 32'(grants[i]), 32'(i % 2));
      chk($sformatf("alt_rsp_id%0d", i), 32'(rids[i]), 32'(i % 2));
      chk($sformatf("alt_rsp_zero%0d", i), 32'(rzero[i]), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("alt_rsp_result%0d", i), 32'(rres[i]), (i % 2 == 0) ? 32'd0 : 32'd1);
    end
    rsp_ready = 1'b0;
    req_valid = '0;

    // Randomized traffic against a transaction-level model
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ops_tbl = '{4'b0000, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1110, ILL_OP};
    ptr_m = 0; busy_m = 1'b0; pend = '0; drop = '0;
    @(posedge clk);
    #1;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (drop[i]) begin
          req_valid[i] = 1'b0; pend[i] = 1'b0; drop[i] = 1'b0;
        end else if (!pend[i] && c < 570 && $urandom_range(0, 2) == 0) begin
          t.a = $urandom; t.b = ($urandom_range(0, 3) == 0) ? t.a : $urandom;
          set_payload(i, ops_tbl[$urandom_range(0, 6)], t.a, t.b, 5'($urandom_range(0, 31)));
          pend[i] = 1'b1; req_valid[i] = 1'b1;
        end
      end
      rsp_ready = (c >= 570) ? 1'b1 : ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (busy_m) begin
        chk("rnd_busy_no_grant", 32'(req_ready), 32'd0);
      end else begin
        g = exp_grant(req_valid, ptr_m);
        if (g < 0) begin
          chk("rnd_idle_no_grant", 32'(req_ready), 32'd0);
        end else begin
          chk("rnd_grant", 32'(req_ready), 32'(1) << g);
          t.id = g; t.op = req_op[4*g +: 4]; t.a = req_a[32*g +: 32];
          t.b = req_b[32*g +: 32]; t.sh = req_shamt[5*g +: 5];
          exp_q.push_back(t);
          ptr_m = (g + 1) % NR; drop[g] = 1'b1; busy_m = 1'b1;
        end
      end
      if (rsp_valid) begin
        chk("rnd_rsp_expected", 32'(exp_q.size() != 0), 32'd1);
        if (rsp_ready && exp_q.size() != 0) begin
          t = exp_q.pop_front();
          ref_rsp(t.op, t.a, t.b, t.sh, r_res, r_z, r_err);
          chk("rnd_rsp_id", 32'(rsp_id), 32'(t.id));
          chk("rnd_rsp_result", rsp_result, r_res);
          chk("rnd_rsp_zero", 32'(rsp_zero), 32'(r_z));
          chk("rnd_rsp_err", 32'(rsp_err), 32'(r_err));
          busy_m = 1'b0;
        end
      end
      @(posedge clk);
      #1;
    end
    chk("rnd_drained", 32'(exp_q.size()), 32'd0);
    chk("rnd_idle_at_end", 32'(rsp_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
